button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Multi-channel front end for the element-board push buttons. Each raw, asynchronous, bouncing input passes through a synchronizer, a debounce filter and an edge detector. Outputs are a clean level plus single-cycle press/release strobes in the clk domain. Downstream counter/display logic uses btn_press as a synchronous increment enable instead of clocking registers directly from a button.

Parameters:
N_BTN, 5, number of button channels
SYNC_STAGES, 2, synchronizer flop depth (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (>=1; 5 ms at 100 MHz)
ACTIVE_LOW, 0, 1 = raw input is pressed-low, inverted before the synchronizer
HOLD_CYCLES, 50000000, auto-repeat initial delay (used only with AUTO_REPEAT_EN)
REPEAT_CYCLES, 10000000, auto-repeat period (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
btn_in  input  N_BTN  raw button pins, asynchronous to clk
btn_level  output  N_BTN  debounced level, 1 = pressed
btn_press  output  N_BTN  one-cycle strobe on accepted press (and on auto-repeat)
btn_release  output  N_BTN  one-cycle strobe on accepted release

Behaviour:
- All outputs registered. Reset: btn_level, btn_press, btn_release = 0; synchronizer flops = 0 (not pressed, after polarity); debounce counters = 0; repeat counters = 0.
- Polarity: s = ACTIVE_LOW ? ~btn_in : btn_in, applied before the first sync flop.
- Channels are fully independent. Per channel there is one debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
- Debounce, per clk edge, with sync = synchronizer output:
  - sync == btn_level: counter cleared to 0.
  - sync != btn_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level toggles and counter clears.
- Latency: if the input changes and stays stable, btn_level changes on edge SYNC_STAGES+DEBOUNCE_CYCLES. Edge 1 is the first edge that samples the new value.
- Any return of sync to btn_level before acceptance clears the counter. A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Strobes are registered on the same edge btn_level toggles:
  - btn_press = 1 for exactly one cycle when btn_level goes 0->1.
  - btn_release = 1 for exactly one cycle when btn_level goes 1->0.
  - Both are 0 on every other cycle.
  - btn_press and btn_release are never both high in one channel in the same cycle.
- A button held through reset release: btn_level stays 0 until full debounce completes, then btn_press fires once.
- Reset asserted mid-debounce: counters and outputs clear immediately (asynchronous), and any pending strobe is lost.
- No wrap-around: the debounce counter saturates by construction and never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
AUTO_REPEAT_EN
- Defined: each channel adds a repeat counter, width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1), cleared whenever btn_level == 0.
  - If the accepted press strobe occurs at edge P, extra btn_press strobes occur at P+HOLD_CYCLES, then every REPEAT_CYCLES after that, while btn_level stays 1.
  - A release cancels repeats with no further strobes; btn_release behaves as normal.
- Undefined: no repeat counters are instantiated. btn_press fires only on debounced 0->1 transitions. HOLD_CYCLES and REPEAT_CYCLES are accepted but ignored.

Test Plan:
(All with N_BTN=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0.)
- Clean press: btn_in[3] 0->1, held 20 cycles.
  - Required: btn_level[3]=1 and btn_press[3]=1 on edge 6; btn_press[3]=0 on edge 7 and later.
  - Required: other channels stay 0.
- Glitch rejection: btn_in[1] high for 3 cycles, then low.
  - Required: btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
- Bounce: btn_in[0] pattern 1,0,1,1,0,1, then held at 1.
  - Required: exactly one btn_press[0] pulse, 6 edges after the last 0->1 transition; no btn_release[0].
- Release: from the pressed state, btn_in[3] 1->0 held.
  - Required: btn_release[3] single pulse and btn_level[3]=0 on edge 6; no btn_press[3].
- Reset mid-operation: n_rst low for 1 cycle at edge 4 of a press; btn_in stays 1.
  - Required: outputs 0 immediately; press strobe arrives 6 edges after reset release.
- Auto-repeat (AUTO_REPEAT_EN defined, HOLD_CYCLES=8, REPEAT_CYCLES=3): hold btn_in[2] for 30 cycles.
  - Required: press strobes at P, P+8, P+11, P+14, and so on until release.
  - Required: the same stimulus without the macro gives a single strobe at P.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: synchronize, debounce and edge-detect N_BTN raw inputs; optional AUTO_REPEAT_EN macro adds hold-to-repeat press strobes.
// Latency: btn_level/strobes register SYNC_STAGES+DEBOUNCE_CYCLES edges after a stable input change.
// Backpressure: none; strobes are single-cycle and are not held for the consumer.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 0,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] w_pol;
  assign w_pol = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_sync;
    logic                   w_diff;
    logic                   w_toggle;
    logic                   w_rpt_fire;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_diff   = (w_sync != r_level);
    assign w_toggle = w_diff && (r_cnt == DB_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_pol[g]};
      end
    end

    // Counter only runs while the synchronized input disagrees with the accepted level.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        if (!w_diff || w_toggle) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_level   <= r_level ^ w_toggle;
        r_press   <= (w_toggle && !r_level) || w_rpt_fire;
        r_release <= w_toggle && r_level;
      end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_phase;
    logic [RW-1:0] w_rpt_last;
    logic          w_rpt_hit;

    // Phase 0 waits out the initial hold, phase 1 paces the repeat period.
    assign w_rpt_last = r_rpt_phase ? RPT_LAST : HOLD_LAST;
    assign w_rpt_hit  = (r_rpt_cnt == w_rpt_last);
    assign w_rpt_fire = r_level && !w_toggle && w_rpt_hit;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_rpt_cnt   <= '0;
        r_rpt_phase <= 1'b0;
      end else if (!r_level) begin
        r_rpt_cnt   <= '0;
        r_rpt_phase <= 1'b0;
      end else if (w_rpt_hit) begin
        r_rpt_cnt   <= '0;
        r_rpt_phase <= 1'b1;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      end
    end
`else
    // Repeat timing is inert here; the expression is constant false.
    assign w_rpt_fire = (HOLD_CYCLES < 0) && (REPEAT_CYCLES < 0);
`endif

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; expectations follow AUTO_REPEAT_EN when it is defined.
module tb_button_conditioner;

  logic       clk;
  logic       n_rst;
  logic [4:0] btn_in;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  button_conditioner #(
    .N_BTN(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
    .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .n_rst(n_rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;
  int pcnt [5];
  int rcnt [5];
  int last_press [5];
  int last_rel [5];
  int lvl_seen [5];
  int both_err = 0;
  int q2 [$];
  int base;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 5; c++) begin
      pcnt[c] = 0; rcnt[c] = 0; last_press[c] = -1; last_rel[c] = -1; lvl_seen[c] = 0;
    end
    q2.delete();
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      ecnt++;
      for (int c = 0; c < 5; c++) begin
        if (btn_press[c]) begin
          pcnt[c]++;
          last_press[c] = ecnt;
          if (c == 2) q2.push_back(ecnt);
        end
        if (btn_release[c]) begin
          rcnt[c]++;
          last_rel[c] = ecnt;
        end
        if (btn_press[c] && btn_release[c]) both_err++;
        if (btn_level[c]) lvl_seen[c] = 1;
      end
    end
  endtask

  initial begin
    n_rst  = 1'b1;
    btn_in = 5'b0;
    clr();
    #2 n_rst = 1'b0;
    #1;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_press", int'(btn_press), 0);
    chk("reset_release", int'(btn_release), 0);
    cyc(2);
    n_rst = 1'b1;
    cyc(3);
    chk("idle_level", int'(btn_level), 0);

    // Clean press on channel 3, held 20 cycles
    clr(); base = ecnt;
    btn_in[3] = 1'b1;
    cyc(5);
    chk("press3_level_e5", int'(btn_level[3]), 0);
    cyc(1);
    chk("press3_level_e6", int'(btn_level[3]), 1);
    chk("press3_strobe_e6", int'(btn_press[3]), 1);
    cyc(1);
    chk("press3_strobe_e7", int'(btn_press[3]), 0);
    cyc(13);
    chk("press3_count", pcnt[3], AUTO ? 4 : 1);
    chk("press3_others_level", int'(btn_level), 5'b01000);
    chk("press3_others_press", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[4], 0);
    chk("press3_no_release", rcnt[3], 0);

    // Release channel 3
    clr(); base = ecnt;
    btn_in[3] = 1'b0;
    cyc(5);
    chk("rel3_level_e5", int'(btn_level[3]), 1);
    cyc(1);
    chk("rel3_level_e6", int'(btn_level[3]), 0);
    chk("rel3_strobe_e6", int'(btn_release[3]), 1);
    chk("rel3_press_e6", int'(btn_press[3]), 0);
    cyc(4);
    chk("rel3_rel_count", rcnt[3], 1);
    chk("rel3_press_count", pcnt[3], AUTO ? 1 : 0);

    // 3-cycle glitch on channel 1 is one short of acceptance
    clr();
    btn_in[1] = 1'b1;
    cyc(3);
    btn_in[1] = 1'b0;
    cyc(10);
    chk("glitch1_level", lvl_seen[1], 0);
    chk("glitch1_press", pcnt[1], 0);
    chk("glitch1_release", rcnt[1], 0);

    // Bounce 1,0,1,1,0 then held 1 on channel 0
    clr();
    btn_in[0] = 1'b1; cyc(1);
    btn_in[0] = 1'b0; cyc(1);
    btn_in[0] = 1'b1; cyc(2);
    btn_in[0] = 1'b0; cyc(1);
    base = ecnt;
    btn_in[0] = 1'b1;
    cyc(8);
    chk("bounce0_press_count", pcnt[0], 1);
    chk("bounce0_press_edge", last_press[0] - base, 6);
    chk("bounce0_no_release", rcnt[0], 0);
    btn_in[0] = 1'b0;
    cyc(8);
    chk("bounce0_release_edge", last_rel[0] - base, 14);
    chk("bounce0_final_press", pcnt[0], 1);

    // Reset pulse at edge 4 of a channel 4 press
    clr();
    btn_in[4] = 1'b1;
    cyc(4);
    n_rst = 1'b0;
    #1;
    chk("rst4_level", int'(btn_level), 0);
    chk("rst4_press", int'(btn_press), 0);
    cyc(1);
    n_rst = 1'b1;
    base = ecnt;
    cyc(7);
    chk("rst4_press_count", pcnt[4], 1);
    chk("rst4_press_edge", last_press[4] - base, 6);
    btn_in[4] = 1'b0;
    cyc(8);
    chk("rst4_release", rcnt[4], 1);

    // Channel 2 held 30 cycles: auto-repeat schedule
    clr(); base = ecnt;
    btn_in[2] = 1'b1;
    cyc(30);
    btn_in[2] = 1'b0;
    cyc(10);
    chk("rpt2_press_count", pcnt[2], AUTO ? 9 : 1);
    chk("rpt2_first_edge", (q2.size() > 0) ? q2[0] - base : -1, 6);
`ifdef AUTO_REPEAT_EN
    chk("rpt2_second_edge", (q2.size() > 1) ? q2[1] - base : -1, 14);
    chk("rpt2_third_edge", (q2.size() > 2) ? q2[2] - base : -1, 17);
    chk("rpt2_fourth_edge", (q2.size() > 3) ? q2[3] - base : -1, 20);
    chk("rpt2_last_edge", (q2.size() > 8) ? q2[8] - base : -1, 35);
`endif
    chk("rpt2_release_count", rcnt[2], 1);
    chk("rpt2_release_edge", last_rel[2] - base, 36);
    chk("never_both_strobes", both_err, 0);
    chk("final_level", int'(btn_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
